dma_bd_ram_arbiter: RTL and testbench

- Shares the DMA controller's buffer-descriptor RAM (128-bit x 128 words, separate registered read/write ports) among several requesters, e.g. register-config writes, descriptor fetch, and status write-back.
- Round-robin arbitration with a lock mechanism for atomic read-modify-write.
- Registers all RAM commands and routes read data back to the requester that issued the read.

---
 rtl/dma_bd_pkg.sv | 22 ++
 rtl/dma_bd_rr_arbiter.sv | 88 ++++++++
 rtl/dma_bd_ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_dma_bd_ram_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_bd_pkg.sv
// Shared definitions for the DMA buffer-descriptor RAM: geometry, requester
// indices and a small width helper.
package dma_bd_pkg;

  localparam int BD_DATA_W = 128;
  localparam int BD_ADDR_W = 7;
  localparam int BD_DEPTH  = 128;

  // Wide enough for the largest supported requester count (8).
  localparam int REQ_IDX_W = 3;
  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  localparam req_idx_t REQ_CFG   = 3'd0;
  localparam req_idx_t REQ_FETCH = 3'd1;
  localparam req_idx_t REQ_WB    = 3'd2;
  localparam req_idx_t REQ_SPARE = 3'd3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_bd_rr_arbiter.sv
// Round-robin grant generator with a single-owner lock for atomic
// read-modify-write sequences. Pure arbitration, no datapath.
module dma_bd_rr_arbiter
  import dma_bd_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] lock_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_vld_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  localparam logic [IDX_W:0]   NREQ = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ-1);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             owner_vld_q, owner_vld_d;
  logic [IDX_W:0]   cand;

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] k);
    return (k == LAST) ? '0 : k + 1'b1;
  endfunction

  // Scanning from the farthest slot back to the pointer lets the last hit
  // be the nearest one, so no early exit is needed.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    cand      = '0;
    if (owner_vld_q) begin
      gnt_vld_o = req_i[owner_q];
      gnt_idx_o = owner_q;
    end else begin
      for (int i = NUM_REQ-1; i >= 0; i--) begin
        cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
        if (cand >= NREQ) cand = cand - NREQ;
        if (req_i[cand[IDX_W-1:0]]) begin
          gnt_vld_o = 1'b1;
          gnt_idx_o = cand[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
  end

  // A locked grant parks the pointer; it only moves again on release.
  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    if (owner_vld_q) begin
      if (!req_i[owner_q] || !lock_i[owner_q]) begin
        owner_vld_d = 1'b0;
        ptr_d       = nxt(owner_q);
      end
    end else if (gnt_vld_o) begin
      if (lock_i[gnt_idx_o]) begin
        owner_vld_d = 1'b1;
        owner_d     = gnt_idx_o;
      end else begin
        ptr_d = nxt(gnt_idx_o);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
    end
  end

endmodule

// File: rtl/dma_bd_ram_arbiter.sv
// Shares the buffer-descriptor RAM among requesters: one grant per cycle,
// registered RAM commands, read data steered back by a tag pipeline.
// Optional DMA_BD_ARB_ADDR_CHK_EN adds out-of-range suppression and addr_err_o.
module dma_bd_ram_arbiter
  import dma_bd_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = BD_ADDR_W,
  parameter  int DATA_W  = BD_DATA_W,
  parameter  int DEPTH   = BD_DEPTH,
  parameter  int RD_LAT  = 1,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      ram_wen_o,
  output logic [ADDR_W-1:0]         ram_waddr_o,
  output logic [DATA_W-1:0]         ram_wdata_o,
  output logic                      ram_ren_o,
  output logic [ADDR_W-1:0]         ram_raddr_o,
  input  logic [DATA_W-1:0]         ram_rdata_i
`ifdef DMA_BD_ARB_ADDR_CHK_EN
  ,
  output logic                      addr_err_o
`endif
);

  if (DEPTH > (1 << ADDR_W) || RD_LAT < 1 || RD_LAT > 3) begin : g_cfg_bad
    $error("dma_bd_ram_arbiter: DEPTH or RD_LAT out of range");
  end

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;

  dma_bd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .lock_i    (lock_i),
    .gnt_o     (gnt),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  assign gnt_o = gnt;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[i*DATA_W +: DATA_W];
        sel_we    = we_i[i];
      end
    end
  end

  logic acc_ok;

`ifdef DMA_BD_ARB_ADDR_CHK_EN
  logic addr_err_q;

  assign acc_ok = ({1'b0, sel_addr} < (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) addr_err_q <= 1'b0;
    else       addr_err_q <= gnt_vld & ~acc_ok;
  end

  assign addr_err_o = addr_err_q;
`else
  assign acc_ok = 1'b1;
`endif

  logic                      ram_wen_q, ram_ren_q;
  logic [ADDR_W-1:0]         ram_waddr_q, ram_raddr_q;
  logic [DATA_W-1:0]         ram_wdata_q;
  logic [RD_LAT:0]           vld_pipe;
  logic [RD_LAT:0]           ok_pipe;
  logic [RD_LAT:0][IDX_W-1:0] tag_pipe;

  // Stage 0 lines up with the RAM command; stage RD_LAT with RAM read data.
  // Suppressed reads still travel the pipe so the requester gets its return.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ram_wen_q   <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_waddr_q <= '0;
      ram_raddr_q <= '0;
      ram_wdata_q <= '0;
      vld_pipe    <= '0;
      ok_pipe     <= '0;
      tag_pipe    <= '0;
    end else begin
      ram_wen_q   <= gnt_vld &  sel_we & acc_ok;
      ram_ren_q   <= gnt_vld & ~sel_we & acc_ok;
      if (gnt_vld & sel_we) begin
        ram_waddr_q <= sel_addr;
        ram_wdata_q <= sel_wdata;
      end
      if (gnt_vld & ~sel_we) ram_raddr_q <= sel_addr;
      vld_pipe[0] <= gnt_vld & ~sel_we;
      ok_pipe[0]  <= acc_ok;
      tag_pipe[0] <= gnt_idx;
      for (int s = 1; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        ok_pipe[s]  <= ok_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  assign ram_wen_o   = ram_wen_q;
  assign ram_ren_o   = ram_ren_q;
  assign ram_waddr_o = ram_waddr_q;
  assign ram_raddr_o = ram_raddr_q;
  assign ram_wdata_o = ram_wdata_q;

  always_comb begin
    rvalid_o = '0;
    if (vld_pipe[RD_LAT]) rvalid_o[tag_pipe[RD_LAT]] = 1'b1;
  end

  assign rdata_o = (vld_pipe[RD_LAT] && ok_pipe[RD_LAT]) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_dma_bd_ram_arbiter.sv
// Directed bench for dma_bd_ram_arbiter with a behavioural 1-cycle RAM.
module tb_dma_bd_ram_arbiter;
  import dma_bd_pkg::*;

  localparam int NR = 4;
  localparam int AW = 7;
  localparam int DW = 128;
  localparam int RL = 1;
`ifdef DMA_BD_ARB_ADDR_CHK_EN
  localparam int DEPTH = 100;
`else
  localparam int DEPTH = 128;
`endif

  localparam logic [DW-1:0] PAT_A = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [DW-1:0] PAT_B = 128'h1357_9BDF_0246_8ACE_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0] req, we, lock, gnt, rvalid;
  logic [NR-1:0][AW-1:0] addr;
  logic [NR-1:0][DW-1:0] wdata;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic ram_wen, ram_ren;
`ifdef DMA_BD_ARB_ADDR_CHK_EN
  logic addr_err;
`endif

  always #5 clk = ~clk;

  dma_bd_ram_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(RL)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .lock_i      (lock),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .ram_wen_o   (ram_wen),
    .ram_waddr_o (ram_waddr),
    .ram_wdata_o (ram_wdata),
    .ram_ren_o   (ram_ren),
    .ram_raddr_o (ram_raddr),
    .ram_rdata_i (ram_rdata)
`ifdef DMA_BD_ARB_ADDR_CHK_EN
    ,
    .addr_err_o  (addr_err)
`endif
  );

  // Behavioural RAM: word n preloads to n*0x11, registered read port.
  logic [DW-1:0] mem [128];
  logic preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int n = 0; n < 128; n++) mem[n] <= DW'(n * 17);
    end else if (ram_wen) begin
      mem[ram_waddr] <= ram_wdata;
    end
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR-1:0] oh(input int k);
    return NR'(1 << k);
  endfunction

  int seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; preload = 1'b1;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    step(); step();
    rst = 1'b0; preload = 1'b0;

    // Reset state and idle
    @(negedge clk);
    chk("rst_addr", DW'({ram_waddr, ram_raddr}), '0);
    chk("rst_wdata", ram_wdata, '0);
    for (int c = 0; c < 10; c++) begin
      chk("idle", DW'({gnt, rvalid, ram_wen, ram_ren}), '0);
      step();
      @(negedge clk);
    end
    step();

    // Round robin over four readers
    for (int i = 0; i < NR; i++) addr[i] = AW'(i + 3);
    req = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) req = '0;
      @(negedge clk);
      chk("rr_gnt", DW'(gnt), (c < 5) ? DW'(oh(seq[c])) : '0);
      if (c == 1) chk("rr_raddr", DW'({ram_ren, ram_raddr}), DW'({1'b1, 7'd3}));
      if (c >= 2) begin
        chk("rr_rvalid", DW'(rvalid), DW'(oh(seq[c-2])));
        chk("rr_rdata", rdata, DW'((seq[c-2] + 3) * 17));
      end else begin
        chk("rr_rvalid0", DW'(rvalid), '0);
      end
      step();
    end

    // Write then read of the same word on consecutive grants
    req = 4'b0110; we = 4'b0010; addr[1] = 7'd5; addr[2] = 7'd5; wdata[1] = PAT_A;
    @(negedge clk);
    chk("raw_gnt_w", DW'(gnt), DW'(4'b0010));
    step();
    req = 4'b0100;
    @(negedge clk);
    chk("raw_gnt_r", DW'(gnt), DW'(4'b0100));
    chk("raw_wcmd", DW'({ram_wen, ram_waddr}), DW'({1'b1, 7'd5}));
    chk("raw_wdata", ram_wdata, PAT_A);
    step();
    req = '0; we = '0;
    @(negedge clk);
    chk("raw_rcmd", DW'({ram_wen, ram_ren, ram_raddr}), DW'({2'b01, 7'd5}));
    step();
    @(negedge clk);
    chk("raw_rvalid", DW'(rvalid), DW'(4'b0100));
    chk("raw_rdata", rdata, PAT_A);
    step();

    // Locked read-modify-write by requester 2
    addr[0] = 7'd3; addr[1] = 7'd4; addr[2] = 7'd9; addr[3] = 7'd6;
    req = 4'b0100; lock = 4'b0100;
    @(negedge clk);
    chk("lock_gnt_rd", DW'(gnt), DW'(4'b0100));
    step();
    req = 4'b1111; we = 4'b0100; lock = '0; wdata[2] = PAT_B;
    @(negedge clk);
    chk("lock_gnt_wr", DW'(gnt), DW'(4'b0100));
    chk("lock_rcmd", DW'({ram_ren, ram_raddr}), DW'({1'b1, 7'd9}));
    step();
    req = 4'b1011; we = '0;
    @(negedge clk);
    chk("lock_after3", DW'(gnt), DW'(4'b1000));
    chk("lock_wcmd", DW'({ram_wen, ram_waddr}), DW'({1'b1, 7'd9}));
    chk("lock_wdata", ram_wdata, PAT_B);
    chk("lock_rvalid", DW'(rvalid), DW'(4'b0100));
    chk("lock_rdata", rdata, DW'(9 * 17));
    step();
    @(negedge clk);
    chk("lock_after0", DW'(gnt), DW'(4'b0001));
    step();

    // Lock released by the owner dropping its request
    req = 4'b0010; lock = 4'b0010;
    @(negedge clk);
    chk("drop_gnt", DW'(gnt), DW'(4'b0010));
    step();
    req = 4'b1101; lock = '0;
    @(negedge clk);
    chk("drop_hold", DW'(gnt), '0);
    step();
    @(negedge clk);
    chk("drop_next", DW'(gnt), DW'(4'b0100));
    step();
    req = '0;
    repeat (4) step();

    // Reset while a read is in flight
    req = 4'b0001; addr[0] = 7'd3;
    @(negedge clk);
    chk("rst_rd_gnt", DW'(gnt), DW'(4'b0001));
    step();
    req = '0; rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_cmd", DW'(ram_ren), DW'(1'b1));
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_rvalid", DW'(rvalid), '0);
      step();
    end
    req = 4'b1001;
    @(negedge clk);
    chk("rst_ptr", DW'(gnt), DW'(4'b0001));
    step();
    req = '0;
    repeat (3) step();

`ifdef DMA_BD_ARB_ADDR_CHK_EN
    // Out-of-range write and read are suppressed
    req = 4'b0001; we = 4'b0001; addr[0] = 7'd120; wdata[0] = PAT_A;
    @(negedge clk);
    chk("oor_w_gnt", DW'(gnt), DW'(4'b0001));
    step();
    req = '0; we = '0;
    @(negedge clk);
    chk("oor_w_cmd", DW'({ram_wen, addr_err}), DW'(2'b01));
    step();
    @(negedge clk);
    chk("oor_w_err_clr", DW'(addr_err), '0);
    step();
    req = 4'b0001;
    @(negedge clk);
    chk("oor_r_gnt", DW'(gnt), DW'(4'b0001));
    step();
    req = '0;
    @(negedge clk);
    chk("oor_r_cmd", DW'({ram_ren, addr_err}), DW'(2'b01));
    step();
    @(negedge clk);
    chk("oor_rvalid", DW'(rvalid), DW'(4'b0001));
    chk("oor_rdata", rdata, '0);
    chk("oor_r_err_clr", DW'(addr_err), '0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
